// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared timing struct, FSM state type and 720p default timing
package video_timing_pkg;
   localparam int TW = 16;
   typedef struct packed {
      logic [TW-1:0] act;
      logic [TW-1:0] fp;
      logic [TW-1:0] sync;
      logic [TW-1:0] bp;
   } timing_t;
   typedef enum logic {IDLE, RUN} state_t;
   localparam int H720_ACT = 1280, H720_FP = 1, H720_SYNC = 50, H720_BP = 200;
   localparam int V720_ACT = 720, V720_FP = 1, V720_SYNC = 5, V720_BP = 5;
   function automatic timing_t mk_timing(input int act, input int fp, input int sync, input int bp);
      return '{act: TW'(act), fp: TW'(fp), sync: TW'(sync), bp: TW'(bp)};
   endfunction
endpackage

// File: rtl/timing_axis.sv
// timing_axis: one-axis position counter with wrap flag and sync/active/lead window decode
// Ports: clk, rstn (async low); clr forces cnt to 0; step advances cnt (wraps at total-1);
//        t = timing of this axis; cnt/pos = position and offset into active area;
//        last = cnt at total-1; sync_on/act_on/lead_on = window decodes (lead = active shifted LEAD earlier).
module timing_axis import video_timing_pkg::*; #(
   parameter int N    = 12,
   parameter int LEAD = 0
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         step,
   input  timing_t      t,
   output logic [N-1:0] cnt,
   output logic [N-1:0] pos,
   output logic         last,
   output logic         sync_on,
   output logic         act_on,
   output logic         lead_on
);
   localparam int CW = TW + 2;
   localparam logic [CW-1:0] L = CW'(LEAD);
   logic [CW-1:0] c, s, e;
   always_comb begin
      c = CW'(cnt);
      s = CW'(t.sync) + CW'(t.bp);
      e = s + CW'(t.act);
      last = c == e + CW'(t.fp) - 1'b1;
      sync_on = c < CW'(t.sync);
      act_on = c >= s && c < e;
      lead_on = c + L >= s && c + L < e;
      pos = N'(c - s);
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (step) cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator (sync, porches, active window)
// Ports: clk, rstn (async low); en = run request; cfg_valid/cfg_ready + cfg_h_*/cfg_v_* = timing update,
//        cfg_err = rejected-config pulse; hsync/vsync/data_en/read_en/x/y/frame_start/line_start =
//        registered timing outputs, one cycle behind the counters.
module video_timing_gen import video_timing_pkg::*; #(
   parameter int   X_BITS     = 12,
   parameter int   Y_BITS     = 11,
   parameter int   DEF_H_ACT  = H720_ACT,
   parameter int   DEF_H_FP   = H720_FP,
   parameter int   DEF_H_SYNC = H720_SYNC,
   parameter int   DEF_H_BP   = H720_BP,
   parameter int   DEF_V_ACT  = V720_ACT,
   parameter int   DEF_V_FP   = V720_FP,
   parameter int   DEF_V_SYNC = V720_SYNC,
   parameter int   DEF_V_BP   = V720_BP,
   parameter logic HS_POL     = 1'b1,
   parameter logic VS_POL     = 1'b1,
   parameter int   READ_LEAD  = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [X_BITS-1:0] cfg_h_act,
   input  logic [X_BITS-1:0] cfg_h_fp,
   input  logic [X_BITS-1:0] cfg_h_sync,
   input  logic [X_BITS-1:0] cfg_h_bp,
   input  logic [Y_BITS-1:0] cfg_v_act,
   input  logic [Y_BITS-1:0] cfg_v_fp,
   input  logic [Y_BITS-1:0] cfg_v_sync,
   input  logic [Y_BITS-1:0] cfg_v_bp,
   output logic              cfg_err,
   output logic              hsync,
   output logic              vsync,
   output logic              data_en,
   output logic              read_en,
   output logic [X_BITS-1:0] x,
   output logic [Y_BITS-1:0] y,
   output logic              frame_start,
   output logic              line_start
);
   localparam int W = (X_BITS > Y_BITS ? X_BITS : Y_BITS) + 2;
   state_t state;
   timing_t cur_h, cur_v, pend_h, pend_v;
   logic pend, run, frame_end, apply, take, bad, de;
   logic [W-1:0] h_tot, v_tot;
   logic [X_BITS-1:0] h_cnt, h_pos;
   logic [Y_BITS-1:0] v_cnt, v_pos;
   logic h_last, h_sync, h_act, h_lead, v_last, v_sync, v_act, v_lead;
   timing_axis #(.N(X_BITS), .LEAD(READ_LEAD)) u_h (
      .clk(clk), .rstn(rstn), .clr(!run), .step(1'b1), .t(cur_h), .cnt(h_cnt), .pos(h_pos),
      .last(h_last), .sync_on(h_sync), .act_on(h_act), .lead_on(h_lead));
   // vertical lead window equals its active window, so read_en shares data_en's line gating
   timing_axis #(.N(Y_BITS), .LEAD(0)) u_v (
      .clk(clk), .rstn(rstn), .clr(!run), .step(h_last), .t(cur_v), .cnt(v_cnt), .pos(v_pos),
      .last(v_last), .sync_on(v_sync), .act_on(v_act), .lead_on(v_lead));
   always_comb begin
      run = state == RUN;
      frame_end = run && h_last && v_last;
      // pending timing lands only where counters restart at 0: frame end or while idle
      apply = pend && (frame_end || !run);
      cfg_ready = !pend;
      take = cfg_valid && cfg_ready;
      h_tot = W'(cfg_h_act) + W'(cfg_h_fp) + W'(cfg_h_sync) + W'(cfg_h_bp);
      v_tot = W'(cfg_v_act) + W'(cfg_v_fp) + W'(cfg_v_sync) + W'(cfg_v_bp);
      bad = cfg_h_act == '0 || cfg_h_sync == '0 || cfg_v_act == '0 || cfg_v_sync == '0 ||
            h_tot > (W'(1) << X_BITS) || v_tot > (W'(1) << Y_BITS);
      de = run && h_act && v_act;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state <= IDLE;
         pend <= 1'b0;
         cfg_err <= 1'b0;
         cur_h <= mk_timing(DEF_H_ACT, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
         cur_v <= mk_timing(DEF_V_ACT, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
         pend_h <= '0;
         pend_v <= '0;
         hsync <= !HS_POL;
         vsync <= !VS_POL;
         data_en <= 1'b0;
         read_en <= 1'b0;
         x <= '0;
         y <= '0;
         frame_start <= 1'b0;
         line_start <= 1'b0;
      end else begin
         state <= run ? (frame_end && !en ? IDLE : RUN) : (en ? RUN : IDLE);
         pend <= (take && !bad) || (pend && !apply);
         cfg_err <= take && bad;
         if (apply) begin
            cur_h <= pend_h;
            cur_v <= pend_v;
         end
         if (take && !bad) begin
            pend_h <= '{act: TW'(cfg_h_act), fp: TW'(cfg_h_fp), sync: TW'(cfg_h_sync), bp: TW'(cfg_h_bp)};
            pend_v <= '{act: TW'(cfg_v_act), fp: TW'(cfg_v_fp), sync: TW'(cfg_v_sync), bp: TW'(cfg_v_bp)};
         end
         hsync <= run && h_sync ? HS_POL : !HS_POL;
         vsync <= run && v_sync ? VS_POL : !VS_POL;
         data_en <= de;
         read_en <= run && h_lead && v_lead;
         x <= de ? h_pos : '0;
         y <= de ? v_pos : '0;
         frame_start <= run && h_cnt == '0 && v_cnt == '0;
         line_start <= run && h_cnt == '0;
      end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench with a frame-position reference model for video_timing_gen
module tb_video_timing_gen;
   localparam int XB = 5, YB = 4, LEAD = 1;
   typedef struct {int act; int fp; int sync; int bp;} tm_t;
   typedef struct packed {
      logic hs, vs, de, re, fs, ls, err, rdy;
      logic [XB-1:0] x;
      logic [YB-1:0] y;
   } out_t;

   logic clk = 1'b0, rstn = 1'b0, en = 1'b0, cfg_valid = 1'b0;
   logic [XB-1:0] cfg_h_act = '0, cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0;
   logic [YB-1:0] cfg_v_act = '0, cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0;
   logic cfg_ready, cfg_err, hsync, vsync, data_en, read_en, frame_start, line_start;
   logic [XB-1:0] x;
   logic [YB-1:0] y;
   int total = 0, bad = 0;

   video_timing_gen #(
      .X_BITS(XB), .Y_BITS(YB),
      .DEF_H_ACT(4), .DEF_H_FP(1), .DEF_H_SYNC(2), .DEF_H_BP(2),
      .DEF_V_ACT(3), .DEF_V_FP(1), .DEF_V_SYNC(1), .DEF_V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .READ_LEAD(LEAD)
   ) dut (
      .clk(clk), .rstn(rstn), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_h_act(cfg_h_act), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
      .cfg_v_act(cfg_v_act), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
      .cfg_err(cfg_err), .hsync(hsync), .vsync(vsync), .data_en(data_en), .read_en(read_en),
      .x(x), .y(y), .frame_start(frame_start), .line_start(line_start));

   always #5 clk = ~clk;

   function automatic int tot(tm_t t);
      return t.act + t.fp + t.sync + t.bp;
   endfunction

   function automatic bit cfg_ok(tm_t h, tm_t v);
      return h.act > 0 && h.sync > 0 && v.act > 0 && v.sync > 0 && tot(h) <= (1 << XB) && tot(v) <= (1 << YB);
   endfunction

   // reference model: position p counts cycles within the frame; h/v derived by division
   bit m_run, m_pend;
   int m_p;
   tm_t mh, mv, ph, pv;
   out_t q[$];

   always @(posedge clk) begin : model
      out_t e;
      tm_t ch, cv;
      int ht, h, v, hb, vb;
      bit vin, tk, good, last;
      e = '0;
      if (!rstn) begin
         m_run = 0; m_p = 0; m_pend = 0;
         mh = '{4, 1, 2, 2};
         mv = '{3, 1, 1, 1};
         e.rdy = 1'b1;
      end else begin
         ht = tot(mh);
         h = m_p % ht;
         v = m_p / ht;
         hb = mh.sync + mh.bp;
         vb = mv.sync + mv.bp;
         vin = v >= vb && v < vb + mv.act;
         e.hs = m_run && h < mh.sync;
         e.vs = m_run && v < mv.sync;
         e.de = m_run && vin && h >= hb && h < hb + mh.act;
         e.re = m_run && vin && h + LEAD >= hb && h + LEAD < hb + mh.act;
         e.x = e.de ? XB'(h - hb) : '0;
         e.y = e.de ? YB'(v - vb) : '0;
         e.fs = m_run && m_p == 0;
         e.ls = m_run && h == 0;
         ch = '{int'(cfg_h_act), int'(cfg_h_fp), int'(cfg_h_sync), int'(cfg_h_bp)};
         cv = '{int'(cfg_v_act), int'(cfg_v_fp), int'(cfg_v_sync), int'(cfg_v_bp)};
         tk = cfg_valid && !m_pend;
         good = cfg_ok(ch, cv);
         e.err = tk && !good;
         last = m_run && m_p == ht * tot(mv) - 1;
         if (m_pend && (last || !m_run)) begin
            mh = ph; mv = pv; m_pend = 0;
         end
         if (!m_run || last) begin
            m_p = 0; m_run = en;
         end else m_p++;
         if (tk && good) begin
            ph = ch; pv = cv; m_pend = 1;
         end
         e.rdy = !m_pend;
      end
      q.push_back(e);
   end

   always @(negedge clk) begin : monitor
      out_t e, g;
      if (q.size() != 0) begin
         e = q.pop_front();
         g = '{hsync, vsync, data_en, read_en, frame_start, line_start, cfg_err, cfg_ready, x, y};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL scoreboard t=%0t got=%h exp=%h (hs vs de re fs ls err rdy x y)", $time, g, e);
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic offer(input tm_t h, input tm_t v);
      cfg_h_act = XB'(h.act); cfg_h_fp = XB'(h.fp); cfg_h_sync = XB'(h.sync); cfg_h_bp = XB'(h.bp);
      cfg_v_act = YB'(v.act); cfg_v_fp = YB'(v.fp); cfg_v_sync = YB'(v.sync); cfg_v_bp = YB'(v.bp);
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_fs(input int lim, output bit ok);
      ok = 0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clk);
         ok = frame_start;
      end
   endtask

   initial begin : main
      bit ok, seen;
      int de_n, re_n, hs_n, xmax, ymax, kde, kre, n;
      tm_t h, v;
      repeat (3) @(negedge clk);
      chk("reset cfg_ready", cfg_ready, 1);
      chk("reset hsync", hsync, 0);
      chk("reset data_en", data_en, 0);
      rstn = 1'b1;
      @(negedge clk);
      en = 1'b1;
      // small-timing frame shape
      wait_fs(200, ok);
      chk("first frame_start seen", ok, 1);
      de_n = 0; re_n = 0; hs_n = 0; xmax = 0; ymax = 0; kde = -1; kre = -1;
      for (int k = 0; k < 54; k++) begin
         if (data_en) begin
            de_n++;
            if (kde < 0) kde = k;
            if (int'(x) > xmax) xmax = int'(x);
            if (int'(y) > ymax) ymax = int'(y);
         end
         if (read_en) begin
            re_n++;
            if (kre < 0) kre = k;
         end
         hs_n += int'(hsync);
         @(negedge clk);
      end
      chk("frame period 54", frame_start, 1);
      chk("data_en count", de_n, 12);
      chk("read_en count", re_n, 12);
      chk("hsync count", hs_n, 12);
      chk("x max", xmax, 3);
      chk("y max", ymax, 2);
      chk("first data_en pos", kde, 22);
      chk("read_en lead", kde - kre, 1);
      // zero active width is rejected
      offer('{0, 1, 1, 1}, '{3, 1, 1, 1});
      chk("cfg_err pulse", cfg_err, 1);
      chk("cfg_ready after reject", cfg_ready, 1);
      @(negedge clk);
      chk("cfg_err single", cfg_err, 0);
      // mid-frame update waits for the frame end
      wait_fs(200, ok);
      chk("frame_start before update", ok, 1);
      repeat (10) @(negedge clk);
      offer('{2, 1, 1, 1}, '{3, 1, 1, 1});
      chk("cfg_ready low while pending", cfg_ready, 0);
      wait_fs(200, ok);
      chk("frame_start after update", ok, 1);
      chk("cfg_ready back after apply", cfg_ready, 1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!line_start && n < 20);
      chk("new line period", n, 5);
      // randomized en and config traffic, incl. total-size boundaries
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) en = ~en;
         if ($urandom_range(0, 29) == 0) begin
            h = '{int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), int'($urandom_range(0, 3))};
            v = '{int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), int'($urandom_range(1, 2)), int'($urandom_range(0, 2))};
            case ($urandom_range(0, 9))
               0: h.act = 0;
               1: v.sync = 0;
               2: h = '{20, 4, 4, 4};
               3: h = '{21, 4, 4, 4};
               4: v = '{10, 2, 2, 2};
               5: v = '{11, 2, 2, 2};
               default: ;
            endcase
            offer(h, v);
         end else @(negedge clk);
      end
      // en dropped mid-frame: frame completes, no restart
      en = 1'b1;
      wait_fs(1200, ok);
      chk("frame_start before en drop", ok, 1);
      repeat (7) @(negedge clk);
      en = 1'b0;
      seen = 0;
      repeat (1100) begin
         @(negedge clk);
         if (frame_start) seen = 1;
      end
      chk("no restart after en drop", seen, 0);
      chk("idle data_en", data_en, 0);
      chk("idle hsync", hsync, 0);
      // asynchronous reset mid-line
      en = 1'b1;
      wait_fs(1200, ok);
      chk("frame_start before reset", ok, 1);
      repeat (3) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("async rst hsync", hsync, 0);
      chk("async rst vsync", vsync, 0);
      chk("async rst data_en", data_en, 0);
      chk("async rst read_en", read_en, 0);
      chk("async rst line_start", line_start, 0);
      chk("async rst cfg_ready", cfg_ready, 1);
      @(negedge clk);
      rstn = 1'b1;
      repeat (150) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter X_BITS, default 12: width of horizontal counter, x and all H config fields.
REQ-002 Parameter Y_BITS, default 11: width of vertical counter, y and all V config fields.
REQ-003 Parameters DEF_H_ACT/FP/SYNC/BP, defaults 1280/1/50/200: horizontal timing loaded at reset.
REQ-004 Parameters DEF_V_ACT/FP/SYNC/BP, defaults 720/1/5/5: vertical timing loaded at reset.
REQ-005 Parameters HS_POL and VS_POL, default 1: active level of hsync and vsync.
REQ-006 Parameter READ_LEAD, default 1, range 0..DEF_H_SYNC+DEF_H_BP: cycles by which read_en leads data_en.
REQ-007 clk  in  1  single clock for all logic.
REQ-008 rstn  in  1  asynchronous, active-low reset.
REQ-009 en  in  1  run request; level-sensitive.
REQ-010 cfg_valid / cfg_ready  in / out  1 each  timing-update handshake.
REQ-011 cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  X_BITS each; cfg_v_* same four fields  in  Y_BITS each.
REQ-012 cfg_err  out  1  one-cycle pulse: offered config rejected.
REQ-013 hsync, vsync, data_en, read_en  out  1 each  timing outputs.
REQ-014 x  out  X_BITS, y  out  Y_BITS: active-area pixel coordinates.
REQ-015 frame_start, line_start  out  1 each  one-cycle pulses.

Function
REQ-016 Line order: sync, back porch, active, front porch; h_cnt 0..H_TOTAL-1, H_TOTAL = SYNC+BP+ACT+FP; same for v_cnt per line.
REQ-017 States IDLE and RUN; IDLE->RUN when en=1 in IDLE; counters start at h=0, v=0 the next cycle.
REQ-018 RUN->IDLE only at frame end (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) with en=0; a running frame always completes.
REQ-019 h_cnt wraps H_TOTAL-1->0 and increments v_cnt; v_cnt wraps V_TOTAL-1->0.
REQ-020 hsync = HS_POL while h_cnt<H_SYNC, else inverse; vsync = VS_POL while v_cnt<V_SYNC, else inverse.
REQ-021 data_en = 1 when h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT).
REQ-022 read_en = data_en window shifted READ_LEAD cycles earlier in h_cnt, same line, same vertical gating.
REQ-023 x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP) while data_en=1; both 0 otherwise.
REQ-024 frame_start = 1 at h=0,v=0; line_start = 1 at every h=0, RUN only.
REQ-025 All outputs registered; they reflect counter position with exactly one cycle latency.
REQ-026 In IDLE: hsync/vsync at inactive level, all other outputs 0.
REQ-027 cfg_ready = 1 when no pending config held; transfer on cfg_valid & cfg_ready.
REQ-028 Config rejected (cfg_err pulse next cycle, nothing stored) if any ACT or SYNC field = 0, or H total > 2^X_BITS, or V total > 2^Y_BITS.
REQ-029 Accepted config becomes pending; applied at the RUN frame-end cycle, or the cycle after acceptance in IDLE; cfg_ready returns to 1 the cycle after apply.
REQ-030 Config accepted during the frame-end cycle applies at the next frame end, never mid-frame.
REQ-031 Totals computed at width max(bits)+2 to avoid overflow.

Reset
REQ-032 rstn=0 asynchronously forces IDLE, counters 0, active timing = DEF_*, pending cleared, cfg_ready=1, outputs per REQ-026, even mid-frame.
REQ-033 Release is synchronous to clk; first RUN needs en sampled high after release.

Structure
REQ-034 Package video_timing_pkg holds timing struct typedef (act/fp/sync/bp), state enum and 720p default constants.
REQ-035 One sub-module timing_axis: one-axis counter, wrap flag, sync/active decode; instantiated for H and V.

Verification
REQ-036 Small timing H 4/1/2/2 (total 9), V 3/1/1/1 (total 6), READ_LEAD=1, en=1 -> 54-cycle frame, 12 data_en cycles, x 0..3, y 0..2, hsync 2 cycles/line.
REQ-037 READ_LEAD=1 -> read_en rises h_cnt=3, data_en at h_cnt=4, both widths 4.
REQ-038 New config H 2/1/1/1 mid-frame -> cfg_ready low until frame end; next frame 5-cycle lines; cfg_ready high one cycle later.
REQ-039 cfg_h_act=0 -> cfg_err single pulse, timing unchanged, cfg_ready stays 1.
REQ-040 en dropped mid-frame -> frame completes, IDLE after last cycle; rstn low mid-line -> outputs inactive immediately.
